// File: rtl/instr_fetch_unit.sv
// Fetch front end: drives the instruction-memory read address, buffers {pc, instruction}
// pairs in a small FIFO, and handles redirects, flushes and fetch faults.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          IMEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instraddr,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam int          PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) << 2;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_RANGE    = 2'd2;

    typedef enum logic {RUN, HALT} state_e;

    state_e             state_q, state_d;
    logic [1:0]         cause_q, cause_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        pc_mem_q    [FIFO_DEPTH];
    logic [31:0]        instr_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic in_range, aligned, full, pop, push;

    assign in_range = {1'b0, fetch_pc_q} < IMEM_BYTES;
    assign aligned  = (redirect_pc[1:0] == 2'b00);
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop      = out_valid && out_ready;
    assign push     = (state_q == RUN) && in_range && (!full || pop) && !redirect_valid;

    assign instraddr = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;
    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;

    // Redirect flushes the queue; a same-cycle pop has already been seen by decode.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (aligned) fetch_pc_d = redirect_pc;
        end else begin
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: the buffer storage is cleared on reset because the reset state of the head is architectural.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]    <= 32'h0;
                instr_mem_q[i] <= 32'h0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= instruction;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        if (redirect_valid) begin
            state_d = aligned ? RUN : HALT;
            cause_d = aligned ? CAUSE_NONE : CAUSE_MISALIGN;
        end else if (state_q == RUN && !in_range) begin
            state_d = HALT;
            cause_d = CAUSE_RANGE;
        end
    end

    always_comb begin
        fault       = (state_q == HALT);
        fault_cause = cause_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;
    localparam int WORDS = 128;
    localparam int BYTES = WORDS * 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instraddr;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [1:0]  fault_cause;

    logic [31:0] imem [WORDS];

    int checks = 0;
    int errors = 0;

    entry_t      mq[$];
    logic [31:0] m_pc;
    bit          m_halt;
    logic [1:0]  m_cause;
    bit          m_live = 0;
    bit          m_just_reset = 0;

    instr_fetch_unit #(
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (DEPTH),
        .IMEM_WORDS (WORDS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .instraddr      (instraddr),
        .instruction    (instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault),
        .fault_cause    (fault_cause)
    );

    always #5 clk = ~clk;

    always_comb begin
        instruction = 32'hDEAD_BEEF;
        if (instraddr < 32'(BYTES)) instruction = imem[instraddr[8:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
        int     sz;
        bit     pop, push;
        entry_t e;
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        if (m_live) begin
            check("instraddr", instraddr, m_pc);
            check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                check("out_pc", out_pc, mq[0].pc);
                check("out_instr", out_instr, mq[0].ins);
            end else if (m_just_reset) begin
                check("reset_out_pc", out_pc, 32'h0);
                check("reset_out_instr", out_instr, 32'h0);
            end
            check("fault", 32'(fault), 32'(m_halt));
            check("fault_cause", 32'(fault_cause), 32'(m_cause));
        end
        m_just_reset = 0;
        if (rst) begin
            mq.delete();
            m_pc         = 32'h0;
            m_halt       = 0;
            m_cause      = 2'd0;
            m_live       = 1;
            m_just_reset = 1;
        end else if (m_live) begin
            sz  = mq.size();
            pop = (sz != 0) && rdy;
            if (rv) begin
                mq.delete();
                if (rpc[1:0] == 2'b00) begin
                    m_pc    = rpc;
                    m_halt  = 0;
                    m_cause = 2'd0;
                end else begin
                    m_halt  = 1;
                    m_cause = 2'd1;
                end
            end else begin
                push = !m_halt && (m_pc < 32'(BYTES)) && (sz < DEPTH || pop);
                if (pop) void'(mq.pop_front());
                if (push) begin
                    e.pc  = m_pc;
                    e.ins = imem[m_pc[8:2]];
                    mq.push_back(e);
                    m_pc = m_pc + 32'd4;
                end else if (!m_halt && m_pc >= 32'(BYTES)) begin
                    m_halt  = 1;
                    m_cause = 2'd2;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, rdy);
    endtask

    initial begin
        logic [31:0] tgt;
        for (int i = 0; i < WORDS; i++) imem[i] = 32'h1000_0000 + 32'(i);

        // Streaming after reset.
        step(1, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        run(8, 1);

        // Backpressure fills the buffer and freezes the fetch address.
        step(1, 0, 32'h0, 0);
        run(5, 0);
        check("bp_frozen_pc", instraddr, 32'h8);
        run(6, 1);

        // Redirect with a full buffer, then redirect coincident with a pop.
        run(3, 0);
        step(0, 1, 32'h40, 0);
        run(3, 1);
        run(2, 0);
        step(0, 1, 32'h80, 1);
        run(4, 1);

        // Misaligned redirect halts; aligned redirect recovers.
        step(0, 1, 32'h42, 1);
        run(4, 1);
        check("misalign_fault", 32'(fault), 32'h1);
        check("misalign_cause", 32'(fault_cause), 32'h1);
        step(0, 1, 32'h20, 1);
        run(4, 1);

        // Run off the end of memory, drain, then reset mid-drain.
        step(0, 1, 32'h1F0, 1);
        run(8, 1);
        check("range_cause", 32'(fault_cause), 32'h2);
        step(0, 1, 32'h1F8, 0);
        run(4, 0);
        run(1, 1);
        step(1, 0, 32'h0, 1);
        run(3, 1);

        // Random traffic over random memory contents.
        for (int i = 0; i < WORDS; i++) imem[i] = $urandom;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                step(1, 0, 32'h0, 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 11) == 0) begin
                tgt = 32'($urandom_range(0, WORDS + 7)) << 2;
                if ($urandom_range(0, 7) == 0) tgt = tgt | 32'($urandom_range(1, 3));
                step(0, 1, tgt, 1'($urandom_range(0, 1)));
            end else begin
                step(0, 0, 32'h0, $urandom_range(0, 9) < 7);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Program-counter and fetch front end that drives the instruction-memory read port and hands fetched words to decode. Each cycle it presents the current fetch PC as a byte address, captures the combinationally returned instruction word, and queues `{pc, instruction}` pairs in a small FIFO. Downstream drains the FIFO through a valid/ready handshake. Branch/jump redirects flush the FIFO, and the block traps on misaligned or out-of-range fetches.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; word-aligned.
- `FIFO_DEPTH`, 2, fetch buffer entries; power of two, 2..8.
- `IMEM_WORDS`, 128, instruction memory size in words; legal byte addresses are 0 .. IMEM_WORDS*4-4.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `instraddr` out 32: byte address to instruction memory; always equals fetch_pc.
- `instruction` in 32: word at `instraddr`, valid in the same cycle (combinational read).
- `redirect_valid` in 1: taken branch/jump this cycle.
- `redirect_pc` in 32: new fetch target.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: decode accepts the head.
- `out_instr` out 32: head instruction.
- `out_pc` out 32: head instruction's byte address.
- `fault` out 1: block is in HALT.
- `fault_cause` out 2: 0 none, 1 misaligned redirect, 2 fetch out of range.

## Operation
- State: `fetch_pc` (32 bits), FIFO storage, `count` (0..FIFO_DEPTH), and FSM `{RUN, HALT}`.
- pop = `out_valid && out_ready`.
- push = RUN && `fetch_pc` < IMEM_WORDS*4 && (count < FIFO_DEPTH || pop) && !`redirect_valid`.
  - A push writes `{fetch_pc, instruction}` at the tail and sets `fetch_pc += 4`.
  - Arithmetic is modulo 2^32.
- When no push occurs, `fetch_pc` holds and `instraddr` stays stable.
- Out of range: if RUN and `fetch_pc` >= IMEM_WORDS*4, go to HALT with `fault_cause`=2.
  - No push occurs.
  - Entries already queued still drain normally.
- Redirect has priority over everything except reset:
  - FIFO is flushed (count=0).
  - A same-cycle pop is still counted as accepted by decode.
  - No push occurs that cycle.
  - If `redirect_pc[1:0]`==0: `fetch_pc`=`redirect_pc`, FSM=RUN, `fault_cause`=0. This is valid from either state, so an aligned redirect exits HALT.
  - If misaligned: `fetch_pc` holds, FSM=HALT, `fault_cause`=1.
  - If the aligned target is out of range, the next cycle enters HALT with cause 2 by the normal rule.
- HALT: no pushes; pops continue until empty. Exit only by reset or aligned redirect.
- `fault` = (FSM==HALT).
- `count` update: +1 on push only, -1 on pop only, unchanged on both or neither.

## Timing
- Reset (synchronous; applies at the edge where `reset`=1 and overrides redirect, push and pop):
  - `fetch_pc`=RESET_PC, count=0, all FIFO storage=0, FSM=RUN.
  - `out_valid`=0, `out_instr`=0, `out_pc`=0, `fault`=0, `fault_cause`=0, `instraddr`=RESET_PC.
- Fetch latency:
  - The word at `instraddr` in cycle N appears at the FIFO head (`out_valid`=1) in cycle N+1, if the FIFO was empty.
  - First cycle after reset release: `instraddr`=RESET_PC; `out_valid`=1 one cycle later.
- Redirect latency:
  - Redirect asserted in cycle N: `out_valid`=0 and `instraddr`=`redirect_pc` in N+1.
  - Target word at the head with `out_valid`=1 in N+2.
- Throughput: one instruction per cycle while `out_ready` is held at 1.
- Full FIFO with `out_ready`=0: `instraddr` frozen, no entries lost or duplicated.
- Full FIFO with pop: push allowed the same cycle; count stays FIFO_DEPTH.
- Head ordering is strict FIFO; `out_pc` of consecutive pops increments by 4 unless a redirect intervenes.
- Outputs are registered/FIFO-sourced. `out_valid`, `out_instr` and `out_pc` have no combinational path from `out_ready` or `redirect_*`.

## Test plan
- Reset then `out_ready`=1, memory preloaded with word i = 32'h1000_0000+i -> pops in consecutive cycles of (pc 0, 32'h1000_0000), (4, 32'h1000_0001), (8, 32'h1000_0002)…; `out_valid` first 1 one cycle after reset release.
- Backpressure: `out_ready`=0 for 5 cycles after reset -> count saturates at 2, `instraddr` frozen at 8. Then `out_ready`=1 -> pcs 0, 4, 8, 12 in order with none skipped.
- Redirect to 32'h40 in cycle N with 2 entries queued -> `out_valid`=0 in N+1, `instraddr`=32'h40 in N+1, head pc 32'h40 in N+2. Redirect coincident with a pop -> popped entry consumed once, rest flushed.
- Misaligned redirect to 32'h42 -> `fault`=1, `fault_cause`=1, no further valid outputs. Then redirect to 32'h20 -> `fault`=0, `fault_cause`=0, head pc 32'h20 two cycles later.
- Sequential fetch to end of memory with IMEM_WORDS=128 -> last pushed pc 32'h1FC, then `fault_cause`=2 when `fetch_pc`=32'h200. Queued entries still pop. Assert `reset` mid-drain -> all outputs return to reset values next cycle.
